// File: rtl/rx_pixel_streamer.sv
// Reads the decrypted R/G/B planes in address order and streams merged {R,G,B} pixels
// over valid/ready, buffering up to four pixels and accumulating a 16-bit checksum.
module rx_pixel_streamer #(
  parameter int NUM_PIXELS = 4096,
  parameter int ADDR_W     = 12,
  parameter int PIX_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 rd_en_o,
  output logic [ADDR_W-1:0]    rd_addr_o,
  input  logic [PIX_W-1:0]     r_data_i,
  input  logic [PIX_W-1:0]     g_data_i,
  input  logic [PIX_W-1:0]     b_data_i,
  output logic [3*PIX_W-1:0]   pix_data_o,
  output logic                 pix_valid_o,
  input  logic                 pix_ready_i,
  output logic                 pix_last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          checksum_o
);

  localparam int ENTRY_W = 3 * PIX_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   issue_q, issue_d;
  logic                inflight_q, inflight_last_q;
  logic [1:0]          wr_ptr_q, rd_ptr_q;
  logic [2:0]          count_q, count_d;
  logic [15:0]         checksum_q, checksum_d;
  logic [ENTRY_W-1:0]  fifo_mem_q [4];

  logic                issue_s, push_s, pop_s, valid_s, start_s;
  logic [ENTRY_W-1:0]  head_s;
  logic [PIX_W-1:0]    head_r_s, head_g_s, head_b_s;

  // FIFO head decode, handshake and read-issue conditions
  always_comb begin
    head_s   = fifo_mem_q[rd_ptr_q];
    head_r_s = head_s[ENTRY_W-1 -: PIX_W];
    head_g_s = head_s[ENTRY_W-1-PIX_W -: PIX_W];
    head_b_s = head_s[PIX_W:1];
    valid_s  = (count_q != 3'd0);
    pop_s    = valid_s && pix_ready_i;
    push_s   = inflight_q;
    start_s  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    // Counting the in-flight read reserves its FIFO slot before the data returns.
    issue_s  = (state_q == S_STREAM) &&
               (({1'b0, count_q} + {3'b000, inflight_q}) <= 4'd3);
  end

  // Next-state, issue counter, FIFO occupancy and checksum
  always_comb begin
    state_d    = state_q;
    issue_d    = issue_q;
    checksum_d = checksum_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_s) begin
          state_d = S_STREAM;
          issue_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_STREAM: begin
        if (issue_s) begin
          issue_d = issue_q + ADDR_W'(1);
          if (issue_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          issue_d = issue_q;
        end
      end
      S_DRAIN: state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase

    if (pop_s && head_s[0] && ((state_q == S_STREAM) || (state_q == S_DRAIN))) begin
      state_d = S_DONE;
    end else begin
      state_d = state_d;
    end

    if (start_s) begin
      checksum_d = 16'd0;
    end else if (pop_s) begin
      checksum_d = checksum_q + 16'(head_r_s) + 16'(head_g_s) + 16'(head_b_s);
    end else begin
      checksum_d = checksum_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state, pointers and checksum; reset drops any pending read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      issue_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      count_q         <= 3'd0;
      checksum_q      <= 16'd0;
    end else begin
      state_q         <= state_d;
      issue_q         <= issue_d;
      inflight_q      <= issue_s;
      inflight_last_q <= issue_s && (issue_q == LAST_ADDR);
      wr_ptr_q        <= push_s ? wr_ptr_q + 2'd1 : wr_ptr_q;
      rd_ptr_q        <= pop_s ? rd_ptr_q + 2'd1 : rd_ptr_q;
      count_q         <= count_d;
      checksum_q      <= checksum_d;
    end
  end

  // FIFO storage; contents are only observed through the occupancy-qualified head
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {r_data_i, g_data_i, b_data_i, inflight_last_q};
    end
  end

  // Output mapping
  always_comb begin
    rd_en_o     = issue_s;
    rd_addr_o   = issue_s ? issue_q : '0;
    pix_valid_o = valid_s;
    pix_data_o  = valid_s ? head_s[ENTRY_W-1:1] : '0;
    pix_last_o  = valid_s && head_s[0];
    busy_o      = (state_q == S_STREAM) || (state_q == S_DRAIN);
    done_o      = (state_q == S_DONE);
    checksum_o  = checksum_q;
  end

endmodule

// File: tb/tb_rx_pixel_streamer.sv
// Bench for rx_pixel_streamer: a 4-pixel and a 256-pixel instance with plane memory models,
// a cycle-exact timing table and randomized streams checked against an address-order model.
module tb_rx_pixel_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, a_start, b_start, pix_ready;
  bit   sel;

  logic        a_rd_en, a_valid, a_last, a_busy, a_done;
  logic [11:0] a_rd_addr;
  logic [7:0]  a_r, a_g, a_b;
  logic [23:0] a_pix;
  logic [15:0] a_cs;
  logic        b_rd_en, b_valid, b_last, b_busy, b_done;
  logic [11:0] b_rd_addr;
  logic [7:0]  b_r, b_g, b_b;
  logic [23:0] b_pix;
  logic [15:0] b_cs;

  logic [7:0] a_rm [4], a_gm [4], a_bm [4];
  logic [7:0] b_rm [256], b_gm [256], b_bm [256];

  rx_pixel_streamer #(.NUM_PIXELS(4), .ADDR_W(12), .PIX_W(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .rd_en_o(a_rd_en), .rd_addr_o(a_rd_addr),
    .r_data_i(a_r), .g_data_i(a_g), .b_data_i(a_b), .pix_data_o(a_pix), .pix_valid_o(a_valid),
    .pix_ready_i(pix_ready), .pix_last_o(a_last), .busy_o(a_busy), .done_o(a_done),
    .checksum_o(a_cs));

  rx_pixel_streamer #(.NUM_PIXELS(256), .ADDR_W(12), .PIX_W(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .rd_en_o(b_rd_en), .rd_addr_o(b_rd_addr),
    .r_data_i(b_r), .g_data_i(b_g), .b_data_i(b_b), .pix_data_o(b_pix), .pix_valid_o(b_valid),
    .pix_ready_i(pix_ready), .pix_last_o(b_last), .busy_o(b_busy), .done_o(b_done),
    .checksum_o(b_cs));

  // Plane memories: data appears one cycle after the read strobe
  always @(posedge clk) begin
    if (a_rd_en) begin
      a_r <= a_rm[a_rd_addr[1:0]];
      a_g <= a_gm[a_rd_addr[1:0]];
      a_b <= a_bm[a_rd_addr[1:0]];
    end
    if (b_rd_en) begin
      b_r <= b_rm[b_rd_addr[7:0]];
      b_g <= b_gm[b_rd_addr[7:0]];
      b_b <= b_bm[b_rd_addr[7:0]];
    end
  end

  logic        m_rd_en, m_valid, m_last, m_busy, m_done;
  logic [11:0] m_rd_addr;
  logic [23:0] m_pix;
  logic [15:0] m_cs;
  assign m_rd_en   = sel ? b_rd_en   : a_rd_en;
  assign m_rd_addr = sel ? b_rd_addr : a_rd_addr;
  assign m_valid   = sel ? b_valid   : a_valid;
  assign m_last    = sel ? b_last    : a_last;
  assign m_pix     = sel ? b_pix     : a_pix;
  assign m_busy    = sel ? b_busy    : a_busy;
  assign m_done    = sel ? b_done    : a_done;
  assign m_cs      = sel ? b_cs      : a_cs;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: pixels in address order, checksum as plain integer sum modulo 2^16
  logic [23:0] exp_q [$];
  logic [15:0] exp_sum;
  int          exp_n;

  task automatic build_exp();
    int sum;
    exp_q.delete();
    sum   = 0;
    exp_n = sel ? 256 : 4;
    for (int k = 0; k < exp_n; k++) begin
      if (sel) begin
        exp_q.push_back({b_rm[k], b_gm[k], b_bm[k]});
        sum += int'(b_rm[k]) + int'(b_gm[k]) + int'(b_bm[k]);
      end else begin
        exp_q.push_back({a_rm[k], a_gm[k], a_bm[k]});
        sum += int'(a_rm[k]) + int'(a_gm[k]) + int'(a_bm[k]);
      end
    end
    exp_sum = 16'(sum % 65536);
  endtask

  task automatic set_start(input logic v);
    if (sel) b_start = v;
    else a_start = v;
  endtask

  task automatic do_start();
    @(negedge clk) set_start(1'b1);
    @(negedge clk) set_start(1'b0);
  endtask

  // mode 0: ready high; 1: alternating, then low 10 cycles, then high; 2: low 10 cycles, then random
  task automatic run_collect(input int mode, input int pulse_at, input int budget);
    logic [23:0] got_q [$];
    logic        got_last_q [$];
    int          issued;
    logic        prev_v, prev_r, seen_done;
    logic [23:0] prev_d;
    issued = 0; prev_v = 1'b0; prev_r = 1'b0; prev_d = 24'd0; seen_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (i > 0) @(negedge clk);
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (i < 6) ? (i % 2 == 0) : (i >= 16);
        default: pix_ready = (i < 10) ? 1'b0 : ($urandom_range(0, 3) != 0);
      endcase
      set_start(i == pulse_at);
      if (m_rd_en) begin
        chk("rd_addr_order", 32'(m_rd_addr), 32'(issued));
        issued++;
      end
      if (prev_v && !prev_r) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_pix), 32'(prev_d));
      end
      if (m_valid && pix_ready) begin
        got_q.push_back(m_pix);
        got_last_q.push_back(m_last);
      end
      if (mode == 2 && i == 9) chk("issue_stops_at_4", 32'(issued), 32'd4);
      if (m_done) begin
        seen_done = 1'b1;
        break;
      end
      prev_v = m_valid; prev_r = pix_ready; prev_d = m_pix;
    end
    set_start(1'b0);
    chk("done_reached", 32'(seen_done), 32'd1);
    chk("pixel_count", 32'(got_q.size()), 32'(exp_n));
    chk("reads_issued", 32'(issued), 32'(exp_n));
    for (int k = 0; k < got_q.size() && k < exp_n; k++) begin
      chk($sformatf("pix[%0d]", k), 32'(got_q[k]), 32'(exp_q[k]));
      chk($sformatf("last[%0d]", k), 32'(got_last_q[k]), 32'(k == exp_n - 1));
    end
    chk("checksum", 32'(m_cs), 32'(exp_sum));
    chk("busy_after_done", 32'(m_busy), 32'd0);
  endtask

  typedef struct {
    logic        ready;
    logic        rd_en;
    logic [11:0] addr;
    logic        valid;
    logic [23:0] data;
    logic        last;
    logic        busy;
    logic        done;
    logic [15:0] cs;
  } row_t;

  row_t tbl [7];

  task automatic check_a_zero(input string tag);
    chk({tag, ".rd_en"}, 32'(a_rd_en), 32'd0);
    chk({tag, ".rd_addr"}, 32'(a_rd_addr), 32'd0);
    chk({tag, ".pix_data"}, 32'(a_pix), 32'd0);
    chk({tag, ".pix_valid"}, 32'(a_valid), 32'd0);
    chk({tag, ".pix_last"}, 32'(a_last), 32'd0);
    chk({tag, ".busy"}, 32'(a_busy), 32'd0);
    chk({tag, ".done"}, 32'(a_done), 32'd0);
    chk({tag, ".checksum"}, 32'(a_cs), 32'd0);
  endtask

  initial begin
    // Timing rows for cycles T+1..T+7 after start on the 4-pixel image with ready high
    tbl[0] = '{1'b1, 1'b1, 12'd0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 12'd1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 12'd2, 1'b1, 24'h000102, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 12'd3, 1'b1, 24'h010203, 1'b0, 1'b1, 1'b0, 16'd3};
    tbl[4] = '{1'b1, 1'b0, 12'd0, 1'b1, 24'h020304, 1'b0, 1'b1, 1'b0, 16'd9};
    tbl[5] = '{1'b1, 1'b0, 12'd0, 1'b1, 24'h030405, 1'b1, 1'b1, 1'b0, 16'd18};
    tbl[6] = '{1'b1, 1'b0, 12'd0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 16'h001E};

    for (int k = 0; k < 4; k++) begin
      a_rm[k] = 8'(k); a_gm[k] = 8'(k + 1); a_bm[k] = 8'(k + 2);
    end
    a_r = 8'd0; a_g = 8'd0; a_b = 8'd0; b_r = 8'd0; b_g = 8'd0; b_b = 8'd0;
    sel = 1'b0; a_start = 1'b0; b_start = 1'b0; pix_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_a_zero("reset");
    chk("reset.b_valid", 32'(b_valid), 32'd0);
    chk("reset.b_busy", 32'(b_busy), 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_a_zero("post_reset_idle");

    // Cycle-exact table run
    pix_ready = 1'b1;
    do_start();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      pix_ready = tbl[i].ready;
      chk($sformatf("tbl%0d.rd_en", i + 1), 32'(a_rd_en), 32'(tbl[i].rd_en));
      chk($sformatf("tbl%0d.rd_addr", i + 1), 32'(a_rd_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d.valid", i + 1), 32'(a_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d.data", i + 1), 32'(a_pix), 32'(tbl[i].data));
      chk($sformatf("tbl%0d.last", i + 1), 32'(a_last), 32'(tbl[i].last));
      chk($sformatf("tbl%0d.busy", i + 1), 32'(a_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d.done", i + 1), 32'(a_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d.checksum", i + 1), 32'(a_cs), 32'(tbl[i].cs));
    end

    // Restart from DONE, backpressure, and a start pulse ignored mid-stream
    @(negedge clk) chk("done_held", 32'(a_done), 32'd1);
    set_start(1'b1);
    @(negedge clk) set_start(1'b0);
    chk("restart.done", 32'(a_done), 32'd0);
    chk("restart.busy", 32'(a_busy), 32'd1);
    chk("restart.rd_en", 32'(a_rd_en), 32'd1);
    chk("restart.rd_addr", 32'(a_rd_addr), 32'd0);
    chk("restart.checksum", 32'(a_cs), 32'd0);
    build_exp();
    run_collect(1, 3, 200);
    chk("a_checksum_1e", 32'(a_cs), 32'h001E);

    // Reset after two transfers while the last read is in flight
    pix_ready = 1'b1;
    do_start();
    repeat (4) @(negedge clk);
    chk("pre_rst.checksum", 32'(a_cs), 32'd9);
    chk("pre_rst.valid", 32'(a_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_a_zero("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_a_zero("after_mid_rst");
    do_start();
    run_collect(0, -1, 100);

    // 256-pixel image of all 0xFF: checksum wraps
    sel = 1'b1;
    for (int k = 0; k < 256; k++) begin
      b_rm[k] = 8'hFF; b_gm[k] = 8'hFF; b_bm[k] = 8'hFF;
    end
    build_exp();
    do_start();
    run_collect(0, -1, 400);
    chk("wrap_checksum_fd00", 32'(b_cs), 32'h0000FD00);
    chk("wrap_done", 32'(b_done), 32'd1);

    // Random images with random backpressure
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 256; k++) begin
        b_rm[k] = 8'($urandom); b_gm[k] = 8'($urandom); b_bm[k] = 8'($urandom);
      end
      build_exp();
      do_start();
      run_collect(2, 40, 3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
